// File: rtl/key_pkg.sv
// Shared definitions for the KEY input conditioning path.
//   KEY_RELEASED          : idle (not pressed) level of an active-low key
//   *_DEFAULT             : default sizing for the debouncer
//   cnt_width()           : minimum counter width able to count to a given number of cycles
package key_pkg;

  localparam logic KEY_RELEASED = 1'b1;

  localparam int unsigned NKEYS_DEFAULT           = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int unsigned CNT_W_DEFAULT           = 20;

  // Smallest w with 2**w >= cycles (at least 1).
  function automatic int unsigned cnt_width(input int unsigned cycles);
    int unsigned w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((64'd1 << w) < 64'(cycles)) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-key conditioner: 2-flop synchroniser, bounce filter counter,
// registered stable level and one-cycle change strobe.
//   clk    : system clock, rising edge
//   rst    : synchronous active-high reset
//   raw    : asynchronous active-low key pin
//   stable : debounced active-low level (registered)
//   chg    : one-cycle pulse when stable changes (registered)
module debounce_bit
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic chg
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             stable_nxt;
  logic             chg_nxt;

  // Filter: count consecutive mismatching cycles, accept on the last one.
  // Any match clears the count, so short pulses never get through.
  always_comb begin
    cnt_nxt    = '0;
    stable_nxt = stable;
    chg_nxt    = 1'b0;
    if (sync2 != stable) begin
      if (cnt < CNT_LAST) begin
        cnt_nxt = cnt + CNT_W'(1);
      end else begin
        stable_nxt = sync2;
        chg_nxt    = 1'b1;
      end
    end
  end

  // State registers; sync1 -> sync2 is a plain flop chain for metastability.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= KEY_RELEASED;
      sync2  <= KEY_RELEASED;
      stable <= KEY_RELEASED;
      cnt    <= '0;
      chg    <= 1'b0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      stable <= stable_nxt;
      cnt    <= cnt_nxt;
      chg    <= chg_nxt;
    end
  end

endmodule

// File: rtl/key_debouncer.sv
// Conditions the raw active-low KEY pins for the KEY device: per-bit
// synchronisation and contact-bounce filtering, plus per-key change strobes.
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   key_raw : raw asynchronous key pins, active-low
//   key_out : debounced active-low key levels (registered)
//   key_chg : one-cycle pulse per key when key_out changes (registered)
module key_debouncer
  import key_pkg::*;
#(
  parameter int unsigned NKEYS           = NKEYS_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] key_raw,
  output logic [NKEYS-1:0] key_out,
  output logic [NKEYS-1:0] key_chg
);

  // Elaboration-time parameter sanity checks.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("key_debouncer: DEBOUNCE_CYCLES must be >= 2");
  end
  if (CNT_W < cnt_width(DEBOUNCE_CYCLES)) begin : g_bad_width
    $error("key_debouncer: CNT_W too small for DEBOUNCE_CYCLES");
  end

  // One independent filter per key.
  for (genvar i = 0; i < int'(NKEYS); i++) begin : g_key
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_bit (
      .clk    (clk),
      .rst    (rst),
      .raw    (key_raw[i]),
      .stable (key_out[i]),
      .chg    (key_chg[i])
    );
  end

endmodule

// File: tb/tb_key_debouncer.sv
module tb_key_debouncer;

  logic       clk;
  logic       rst;
  logic [3:0] key_raw;
  logic [3:0] key_out;
  logic [3:0] key_chg;

  int checks;
  int errors;

  key_debouncer #(
    .NKEYS           (4),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .key_raw (key_raw),
    .key_out (key_out),
    .key_chg (key_chg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges; returns 1 time unit after the last edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_both(input string tag, input logic [3:0] out_exp, input logic [3:0] chg_exp);
    chk({tag, "_out"}, key_out, out_exp);
    chk({tag, "_chg"}, key_chg, chg_exp);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    key_raw = 4'h0;

    // Reset with keys held: outputs forced to released.
    step(2);
    chk_both("reset", 4'hF, 4'h0);
    rst = 1'b0;
    step(5);
    chk_both("post_rst_e5", 4'hF, 4'h0);
    step(1);
    chk_both("post_rst_e6", 4'h0, 4'hF);
    step(1);
    chk_both("post_rst_e7", 4'h0, 4'h0);

    // Release all keys.
    key_raw = 4'hF;
    step(5);
    chk_both("rel_all_e5", 4'h0, 4'h0);
    step(1);
    chk_both("rel_all_e6", 4'hF, 4'hF);
    step(1);
    chk_both("rel_all_e7", 4'hF, 4'h0);

    // Clean press of key 0.
    key_raw = 4'hE;
    step(5);
    chk_both("press_e5", 4'hF, 4'h0);
    step(1);
    chk_both("press_e6", 4'hE, 4'h1);
    step(1);
    chk_both("press_e7", 4'hE, 4'h0);
    step(10);
    chk_both("press_hold", 4'hE, 4'h0);
    key_raw = 4'hF;
    step(6);
    chk_both("press_rel", 4'hF, 4'h1);
    step(1);

    // Bounce on key 0: 2-cycle phases never reach the 4-cycle threshold.
    for (int i = 0; i < 10; i++) begin
      key_raw = (i % 2 == 0) ? 4'hE : 4'hF;
      for (int j = 0; j < 2; j++) begin
        step(1);
        chk_both("bounce", 4'hF, 4'h0);
      end
    end
    key_raw = 4'hE;
    for (int j = 0; j < 5; j++) begin
      step(1);
      chk_both("bounce_settle", 4'hF, 4'h0);
    end
    step(1);
    chk_both("bounce_accept", 4'hE, 4'h1);
    step(1);
    chk_both("bounce_after", 4'hE, 4'h0);
    key_raw = 4'hF;
    step(6);
    chk_both("bounce_rel", 4'hF, 4'h1);
    step(1);

    // Glitch on key 1 for 3 cycles: rejected.
    key_raw = 4'hD;
    step(3);
    key_raw = 4'hF;
    for (int j = 0; j < 10; j++) begin
      step(1);
      chk_both("glitch", 4'hF, 4'h0);
    end

    // Simultaneous press of keys 0 and 3.
    key_raw = 4'h6;
    step(5);
    chk_both("simul_e5", 4'hF, 4'h0);
    step(1);
    chk_both("simul_e6", 4'h6, 4'h9);
    step(1);
    chk_both("simul_e7", 4'h6, 4'h0);
    key_raw = 4'hF;
    step(6);
    chk_both("simul_rel", 4'hF, 4'h9);
    step(1);
    chk_both("simul_rel_after", 4'hF, 4'h0);

    // Reset mid-count on key 2, then re-acceptance.
    key_raw = 4'hB;
    step(5);
    chk_both("midrst_count", 4'hF, 4'h0);
    rst = 1'b1;
    step(1);
    chk_both("midrst_r1", 4'hF, 4'h0);
    step(1);
    chk_both("midrst_r2", 4'hF, 4'h0);
    rst = 1'b0;
    step(5);
    chk_both("midrst_e5", 4'hF, 4'h0);
    step(1);
    chk_both("midrst_e6", 4'hB, 4'h4);
    step(1);
    chk_both("midrst_e7", 4'hB, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
